ppa_mp_add_ctrl: RTL and testbench
==================================

Name: ppa_mp_add_ctrl

Overview:
Multi-precision add/subtract sequencer for the 16-bit prefix-parallel adder datapath. It accepts WORDS×16-bit operands over a valid/ready handshake and drives one external combinational 16-bit adder for WORDS consecutive cycles, least significant word first, chaining the carry between words. It returns the full-width result, carry-out and signed overflow over a second valid/ready handshake. It sits between an operand producer (ALU issue logic) and the shared adder instance.

Parameters:
WORDS, 4, number of 16-bit words per operand (legal 2..16)
W, 16, adder slice width; fixed, must equal the datapath adder width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort; returns to IDLE, discards operation
in_valid  input  1  operand request valid
in_ready  output  1  controller can accept operands
in_a  input  WORDS*W  operand A
in_b  input  WORDS*W  operand B
in_sub  input  1  1 = A−B, 0 = A+B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  WORDS*W  result
out_cout  output  1  final carry (for subtract: 1 = no borrow)
out_ovf  output  1  two's-complement signed overflow
add_a  output  W  adder operand A slice
add_b  output  W  adder operand B slice (already inverted for subtract)
add_cin  output  1  adder carry-in
add_s  input  W  adder sum
add_cout  input  1  adder carry-out (true carry out of bit 15)

Behaviour:
- Single clock domain. rst_n is asynchronous and active-low; every flop resets asynchronously.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, add_a=0, add_b=0, add_cin=0, word index=0, carry=0.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready:
    - latch A, B, sub
    - idx←0, carry←in_sub, result←0
    - go to RUN
  - RUN: in_ready=0, out_valid=0.
    - Combinationally drive add_a=A[idx], add_b=B[idx]^{W{sub}}, add_cin=carry.
    - Each edge: result[idx]←add_s, carry←add_cout.
    - If idx==WORDS−1: out_cout←add_cout; out_ovf←(A.msb == B'.msb) & (add_s.msb != A.msb), where B' is the inverted B for subtract; go to DONE.
    - Otherwise idx←idx+1.
  - DONE: out_valid=1; out_sum, out_cout and out_ovf held stable. On out_ready go to IDLE and clear out_valid.
- add_a, add_b and add_cin are 0 outside RUN.
- Latency: acceptance edge at cycle 0; out_valid rises WORDS edges later. Minimum initiation interval is WORDS+2 cycles: no overlap, in_ready is only 1 in IDLE.
- Width rules:
  - idx is clog2(WORDS) bits; it never wraps past WORDS−1.
  - Sum bits beyond WORDS*W are discarded; the final carry goes to out_cout.
- in_valid while busy is ignored (in_ready=0); the producer must hold its request.
- clr has priority over every transition:
  - next state IDLE, out_valid←0
  - out_sum, out_cout and out_ovf cleared
  - a same-cycle in_valid is not accepted
- rst_n assertion mid-RUN or in DONE returns all state and outputs to reset values immediately; no partial result is emitted.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package ppa_pkg holds:
  - constant PPA_W=16
  - state enum {IDLE, RUN, DONE}
  - helper function for the signed-overflow expression
- Word selection is a plain indexed part-select in the controller; no sub-module is needed.
- The 16-bit prefix adder stays external, wired via the add_* ports. The bench instantiates a reference adder behind the add_* ports with a correct carry-out.

Test Plan:
- Add 0x0000_0000_0000_FFFF + 0x1, sub=0 -> out_sum=0x0000_0000_0001_0000, cout=0, ovf=0; out_valid exactly 4 cycles after acceptance.
- Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> out_sum=0, cout=1, ovf=0. Add 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> out_sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- Subtract 0x0 − 0x1 -> out_sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0. Subtract 0x8000_0000_0000_0000 − 0x1 -> out_sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_sum/cout/ovf stable, in_ready=0, new in_valid ignored. Release -> IDLE next cycle, then the pending request is accepted.
- rst_n pulsed low while idx=2 in RUN -> all outputs 0 asynchronously, in_ready=1 after release. Next operation 0x1234 + 0x4321 -> 0x5555. Repeat with clr instead of reset -> same result.
- Random: 2000 random A/B/sub with random out_ready stalls -> out_sum, cout and ovf match a 64-bit golden model; latency always 4.

Source files
------------

// File: rtl/ppa_pkg.sv
// Shared definitions for the prefix-parallel adder (PPA) datapath.
//   PPA_W      : width of one adder slice
//   state_t    : multi-precision sequencer states
//   signed_ovf : two's-complement overflow from the top-slice sign bits
package ppa_pkg;

  localparam int PPA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Overflow occurs when both addends share a sign and the sum's sign differs.
  // b_msb must be the sign of the operand actually presented to the adder
  // (i.e. already inverted for subtract).
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/ppa_mp_add_ctrl.sv
// Multi-precision add/subtract sequencer for the shared 16-bit prefix adder.
// Accepts WORDS x W-bit operands, walks them through the external adder one
// slice per cycle (least significant first) chaining the carry, and returns
// the full result with carry-out and signed overflow.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   clr                 synchronous abort back to IDLE, result cleared
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   in_a, in_b, in_sub  operands and operation select (1 = A - B)
//   out_valid/out_ready result handshake
//   out_sum             WORDS*W-bit result
//   out_cout            final carry (subtract: 1 = no borrow)
//   out_ovf             two's-complement signed overflow
//   add_a, add_b        slice operands to the external adder (B pre-inverted
//                       for subtract); zero outside RUN
//   add_cin             slice carry-in; zero outside RUN
//   add_s, add_cout     slice sum and carry-out from the external adder
module ppa_mp_add_ctrl
  import ppa_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int W     = PPA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORDS*W-1:0] in_a,
  input  logic [WORDS*W-1:0] in_b,
  input  logic               in_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORDS*W-1:0] out_sum,
  output logic               out_cout,
  output logic               out_ovf,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  output logic               add_cin,
  input  logic [W-1:0]       add_s,
  input  logic               add_cout
);

  localparam int                TOT_W    = WORDS * W;
  localparam int                IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               sub_q;
  logic [TOT_W-1:0]   a_q;
  logic [TOT_W-1:0]   b_q;
  logic [TOT_W-1:0]   sum_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = sum_q;

  // Slice selection feeds the external combinational adder in the same cycle,
  // so these cannot be registered.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_q[idx*W +: W];
      add_b   = b_q[idx*W +: W] ^ {W{sub_q}};
      add_cin = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (clr) begin
      // Abort wins over everything, including a same-cycle request.
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      sum_q    <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            sub_q <= in_sub;
            idx   <= '0;
            // Subtract is A + ~B + 1: the +1 enters as the first carry-in.
            carry <= in_sub;
            sum_q <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*W +: W] <= add_s;
          carry             <= add_cout;
          if (idx == LAST_IDX) begin
            out_cout <= add_cout;
            out_ovf  <= signed_ovf(add_a[W-1], add_b[W-1], add_s[W-1]);
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppa_mp_add_ctrl.sv
module tb_ppa_mp_add_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 16;
  localparam int TW    = WORDS * W;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_a;
  logic [TW-1:0] in_b;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic          add_cin;
  logic [W-1:0]  add_s;
  logic          add_cout;

  logic rdy_manual;
  logic rand_rdy;
  logic rnd_bit;

  assign out_ready = rand_rdy ? rnd_bit : rdy_manual;

  // Reference slice adder behind the add_* ports.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

  ppa_mp_add_ctrl #(.WORDS(WORDS), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          sub;
    logic [TW-1:0] sum;
    logic          cout;
    logic          ovf;
  } vec_t;

  vec_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   acc_cycle = 0;

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Independent full-width golden model.
  function automatic vec_t model(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic s);
    vec_t v;
    logic [TW-1:0] bp;
    logic [TW:0]   r;
    bp     = s ? ~b : b;
    r      = {1'b0, a} + {1'b0, bp} + {{TW{1'b0}}, s};
    v.a    = a;
    v.b    = b;
    v.sub  = s;
    v.sum  = r[TW-1:0];
    v.cout = r[TW];
    v.ovf  = (a[TW-1] == bp[TW-1]) && (r[TW-1] != a[TW-1]);
    return v;
  endfunction

  // Call at posedge+#1. Holds the request until accepted; returns at posedge+#1
  // just after the accepting edge.
  task automatic send(input vec_t v, input bit push);
    bit ok;
    ok       = 1'b0;
    in_a     = v.a;
    in_b     = v.b;
    in_sub   = v.sub;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready && !clr) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("accept");
      in_valid = 1'b0;
      return;
    end
    acc_cycle = cycle + 1;
    if (push) q.push_back(v);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic prev;
    vec_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev)
        chk("latency", TW'(cycle - acc_cycle), TW'(WORDS));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %h want none", out_sum);
        end else begin
          e = q.pop_front();
          chk("sum",  out_sum, e.sum);
          chk("cout", TW'(out_cout), TW'(e.cout));
          chk("ovf",  TW'(out_ovf),  TW'(e.ovf));
        end
      end
      prev = out_valid;
    end
  endtask

  task automatic rnd_ready();
    forever begin
      @(posedge clk);
      #1 rnd_bit = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  TW'(in_ready),  TW'(1));
    chk({tag, "_out_valid"}, TW'(out_valid), TW'(0));
    chk({tag, "_out_sum"},   out_sum,        TW'(0));
    chk({tag, "_out_cout"},  TW'(out_cout),  TW'(0));
    chk({tag, "_out_ovf"},   TW'(out_ovf),   TW'(0));
    chk({tag, "_add_a"},     TW'(add_a),     TW'(0));
    chk({tag, "_add_b"},     TW'(add_b),     TW'(0));
    chk({tag, "_add_cin"},   TW'(add_cin),   TW'(0));
  endtask

  vec_t tbl[7];
  vec_t v, v2, dummy;
  logic [TW-1:0] snap_sum;
  logic          snap_cout, snap_ovf;
  int            rel_cycle;
  bit            seen;

  initial begin
    tbl[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0,                   1'b1, 1'b0};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[3] = '{64'h0,                   64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tbl[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{64'h1234,                64'h4321, 1'b0, 64'h5555,             1'b0, 1'b0};
    tbl[6] = '{64'h0000_0001_0000_0000, 64'h1, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0};

    rst_n      = 1'b0;
    clr        = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_sub     = 1'b0;
    rdy_manual = 1'b1;
    rand_rdy   = 1'b0;
    rnd_bit    = 1'b1;

    #2;
    chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    fork
      monitor();
      rnd_ready();
    join_none

    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      send(tbl[i], 1'b1);
      wait_idle(100);
    end

    // Backpressure in DONE with a pending request
    rdy_manual = 1'b0;
    v  = model(64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
    v2 = model(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0002, 1'b1);
    send(v, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("bp_out_valid");
    snap_sum  = out_sum;
    snap_cout = out_cout;
    snap_ovf  = out_ovf;
    in_a      = v2.a;
    in_b      = v2.b;
    in_sub    = v2.sub;
    in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", TW'(out_valid), TW'(1));
      chk("bp_sum_stable", out_sum, snap_sum);
      chk("bp_cout_stable", TW'(out_cout), TW'(snap_cout));
      chk("bp_ovf_stable", TW'(out_ovf), TW'(snap_ovf));
      chk("bp_in_ready", TW'(in_ready), TW'(0));
      chk("bp_add_cin", TW'(add_cin), TW'(0));
    end
    @(posedge clk);
    #1 rdy_manual = 1'b1;
    rel_cycle = cycle;
    send(v2, 1'b1);
    chk("bp_accept_delay", TW'(acc_cycle - rel_cycle), TW'(2));
    wait_idle(100);

    // Asynchronous reset mid-RUN (idx = 2)
    dummy = model(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
    send(dummy, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midrun_rst");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_in_ready", TW'(in_ready), TW'(1));
    send(tbl[5], 1'b1);
    wait_idle(100);

    // Synchronous clear mid-RUN (idx = 2)
    send(dummy, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", TW'(out_valid), TW'(0));
    chk("clr_in_ready", TW'(in_ready), TW'(1));
    chk("clr_out_sum", out_sum, TW'(0));
    chk("clr_add_cin", TW'(add_cin), TW'(0));
    @(posedge clk);
    #1;
    send(tbl[5], 1'b1);
    wait_idle(100);

    // clr blocks a same-cycle request in IDLE
    in_a     = 64'h5;
    in_b     = 64'h6;
    in_sub   = 1'b0;
    in_valid = 1'b1;
    clr      = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_block_in_ready", TW'(in_ready), TW'(1));
    chk("clr_block_add_a", TW'(add_a), TW'(0));
    for (int k = 0; k < WORDS + 2; k++) begin
      @(negedge clk);
      chk("clr_block_out_valid", TW'(out_valid), TW'(0));
    end
    @(posedge clk);
    #1;

    // Random operands with random out_ready stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      logic [TW-1:0] a, b;
      logic s;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 15))
        0: b = ~a;
        1: b = a;
        2: a = {1'b0, {(TW-1){1'b1}}};
        3: a = {1'b1, {(TW-1){1'b0}}};
        default: ;
      endcase
      send(model(a, b, s), 1'b1);
    end
    wait_idle(2000);
    rand_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
